// File: rtl/insn_sequencer_pkg.sv
// Shared definitions for the fetch/execute sequencer: opcodes, widths,
// FSM state encoding and execution-unit selector.
package insn_sequencer_pkg;

   localparam int INSN_W = 4;

   localparam logic [INSN_W-1:0] OP_NOP        = 4'h0;
   localparam logic [INSN_W-1:0] OP_INC        = 4'h1;
   localparam logic [INSN_W-1:0] OP_DEC        = 4'h2;
   localparam logic [INSN_W-1:0] OP_RIGHT      = 4'h3;
   localparam logic [INSN_W-1:0] OP_LEFT       = 4'h4;
   localparam logic [INSN_W-1:0] OP_LOOP_OPEN  = 4'h5;
   localparam logic [INSN_W-1:0] OP_LOOP_CLOSE = 4'h6;
   localparam logic [INSN_W-1:0] OP_OUT        = 4'h7;
   localparam logic [INSN_W-1:0] OP_IN         = 4'h8;
   localparam logic [INSN_W-1:0] OP_HALT       = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DISPATCH,
      S_EX_REQ,
      S_EX_WAIT,
      S_FETCH_REQ,
      S_FETCH_WAIT,
      S_COMMIT,
      S_HALTED
   } seq_state_e;

   typedef enum logic [1:0] {
      U_DATA,
      U_AP,
      U_IO
   } exec_unit_e;

endpackage

// File: rtl/insn_sequencer_decoder.sv
// Combinational instruction decoder: one-hot operation class plus a direction
// bit (DEC, LEFT and IN set dir; loop codes and 9..E are pure fetches).
module insn_sequencer_decoder
   import insn_sequencer_pkg::*;
(
   input  logic [INSN_W-1:0] insn,
   output logic              is_data,
   output logic              is_ap,
   output logic              is_io,
   output logic              is_halt,
   output logic              is_fetch_only,
   output logic              dir
);

   always_comb begin
      is_data       = 1'b0;
      is_ap         = 1'b0;
      is_io         = 1'b0;
      is_halt       = 1'b0;
      is_fetch_only = 1'b0;
      dir           = 1'b0;
      case (insn)
         OP_INC:   is_data = 1'b1;
         OP_DEC:   begin is_data = 1'b1; dir = 1'b1; end
         OP_RIGHT: is_ap = 1'b1;
         OP_LEFT:  begin is_ap = 1'b1; dir = 1'b1; end
         OP_OUT:   is_io = 1'b1;
         OP_IN:    begin is_io = 1'b1; dir = 1'b1; end
         OP_HALT:  is_halt = 1'b1;
         default:  is_fetch_only = 1'b1;
      endcase
   end

endmodule

// File: rtl/insn_sequencer.sv
// Fetch/execute controller: runs one instruction on the data, AP or IO unit,
// then asks the IP line to advance; run/step/halt control and instruction count.
module insn_sequencer
   import insn_sequencer_pkg::*;
#(
   parameter int INSN_WIDTH = INSN_W,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  Run,
   input  logic                  Step,
   input  logic                  HaltRq,
   output logic                  Busy,
   output logic                  Halted,
   output logic                  IpRequest,
   input  logic                  IpReady,
   input  logic [INSN_WIDTH-1:0] Insn,
   output logic                  DataIsZeroed,
   output logic                  ApRequest,
   output logic                  ApDec,
   input  logic                  ApReady,
   output logic                  DataRequest,
   output logic                  DataDec,
   input  logic                  DataReady,
   input  logic                  DataZero,
   output logic                  OutRequest,
   output logic                  InRequest,
   input  logic                  IoReady,
   output logic [CNT_WIDTH-1:0]  InsnCount
);

   seq_state_e state;
   exec_unit_e unit_q;
   logic       step_mode;
   logic       first_wait;
   logic       unit_ready;

   logic is_data, is_ap, is_io, is_halt, is_fetch_only, dir;

   insn_sequencer_decoder u_dec (
      .insn          (Insn),
      .is_data       (is_data),
      .is_ap         (is_ap),
      .is_io         (is_io),
      .is_halt       (is_halt),
      .is_fetch_only (is_fetch_only),
      .dir           (dir)
   );

   always_comb begin
      unit_ready = IoReady;
      case (unit_q)
         U_DATA:  unit_ready = DataReady;
         U_AP:    unit_ready = ApReady;
         default: unit_ready = IoReady;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state        <= S_IDLE;
         unit_q       <= U_DATA;
         step_mode    <= 1'b0;
         first_wait   <= 1'b0;
         Busy         <= 1'b0;
         Halted       <= 1'b0;
         IpRequest    <= 1'b0;
         ApRequest    <= 1'b0;
         ApDec        <= 1'b0;
         DataRequest  <= 1'b0;
         DataDec      <= 1'b0;
         OutRequest   <= 1'b0;
         InRequest    <= 1'b0;
         DataIsZeroed <= 1'b0;
         InsnCount    <= '0;
      end else begin
         // Requests and their direction bits are single-cycle pulses.
         IpRequest   <= 1'b0;
         ApRequest   <= 1'b0;
         ApDec       <= 1'b0;
         DataRequest <= 1'b0;
         DataDec     <= 1'b0;
         OutRequest  <= 1'b0;
         InRequest   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!HaltRq && (Run || Step)) begin
                  state     <= S_DISPATCH;
                  Busy      <= 1'b1;
                  step_mode <= ~Run;
               end
            end
            S_DISPATCH: begin
               if (is_halt) begin
                  state  <= S_HALTED;
                  Busy   <= 1'b0;
                  Halted <= 1'b1;
               end else if (is_fetch_only) begin
                  state     <= S_FETCH_REQ;
                  IpRequest <= 1'b1;
               end else begin
                  state       <= S_EX_REQ;
                  DataRequest <= is_data;
                  DataDec     <= is_data & dir;
                  ApRequest   <= is_ap;
                  ApDec       <= is_ap & dir;
                  OutRequest  <= is_io & ~dir;
                  InRequest   <= is_io & dir;
                  unit_q      <= is_data ? U_DATA : (is_ap ? U_AP : U_IO);
               end
            end
            S_EX_REQ: begin
               state      <= S_EX_WAIT;
               first_wait <= 1'b1;
            end
            S_EX_WAIT: begin
               // Ready in the first wait cycle may still be stale from before the request.
               if (first_wait) begin
                  first_wait <= 1'b0;
               end else if (unit_ready) begin
                  state     <= S_FETCH_REQ;
                  IpRequest <= 1'b1;
                  if (unit_q != U_IO) DataIsZeroed <= DataZero;
               end
            end
            S_FETCH_REQ: begin
               state      <= S_FETCH_WAIT;
               first_wait <= 1'b1;
            end
            S_FETCH_WAIT: begin
               if (first_wait) begin
                  first_wait <= 1'b0;
               end else if (IpReady) begin
                  state <= S_COMMIT;
               end
            end
            S_COMMIT: begin
               InsnCount <= InsnCount + CNT_WIDTH'(1);
               if (step_mode || HaltRq || !Run) begin
                  state <= S_IDLE;
                  Busy  <= 1'b0;
               end else begin
                  state <= S_DISPATCH;
               end
            end
            S_HALTED: Halted <= 1'b1;
            default:  state  <= S_IDLE;
         endcase
      end
   end

endmodule
